// File: rtl/bp_pkg.sv
// Shared types and constants for the E-stage branch resolver.
package bp_pkg;

  // Bit 3 marks the branch-likely variant; bits 2:0 select the compare.
  typedef enum logic [3:0] {
    BR_EQ    = 4'h0,
    BR_NE    = 4'h1,
    BR_LEZ   = 4'h2,
    BR_GTZ   = 4'h3,
    BR_LTZ   = 4'h4,
    BR_GEZ   = 4'h5,
    BR_EQ_L  = 4'h8,
    BR_NE_L  = 4'h9,
    BR_LEZ_L = 4'hA,
    BR_GTZ_L = 4'hB,
    BR_LTZ_L = 4'hC,
    BR_GEZ_L = 4'hD
  } br_type_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_DS  = 2'd1,
    ST_REDIRECT = 2'd2
  } resolve_state_t;

  // Fall-through PC of a branch skips its delay slot.
  localparam logic [31:0] DS_OFFSET = 32'd8;

  // Taken target: slot PC + 4 + sign-extended word offset, wrapping mod 2^32.
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/br_cmp.sv
// Per-slot branch condition evaluator: operands and branch type to take/likely.
module br_cmp
  import bp_pkg::*;
#(
  parameter int TYPE_W = 4
) (
  input  logic [31:0]       a_i,
  input  logic [31:0]       b_i,
  input  logic [TYPE_W-1:0] type_i,
  output logic              take_o,
  output logic              likely_o
);

  logic signed [31:0] a_s;
  br_type_t           base;

  assign a_s      = a_i;
  assign base     = br_type_t'({1'b0, type_i[2:0]});
  assign likely_o = type_i[3] & (type_i[2:0] <= 3'd5);

  // Evaluate the compare selected by the base type; unknown codes never take.
  always_comb begin
    take_o = 1'b0;
    case (base)
      BR_EQ:   take_o = (a_i == b_i);
      BR_NE:   take_o = (a_i != b_i);
      BR_LEZ:  take_o = (a_s <= 32'sd0);
      BR_GTZ:  take_o = (a_s >  32'sd0);
      BR_LTZ:  take_o = a_i[31];
      BR_GEZ:  take_o = ~a_i[31];
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_e.sv
// E-stage branch resolver: evaluates one branch per cycle, reports outcome,
// flushes and redirects fetch on mispredict, honours the delay slot.
module branch_resolve_e
  import bp_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int TYPE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_e,
  input  logic              branch1E,
  input  logic              branch2E,
  input  logic              pred_take1E,
  input  logic              pred_take2E,
  input  logic [TYPE_W-1:0] br_type1E,
  input  logic [TYPE_W-1:0] br_type2E,
  input  logic [31:0]       rs1E,
  input  logic [31:0]       rt1E,
  input  logic [31:0]       rs2E,
  input  logic [31:0]       rt2E,
  input  logic [15:0]       imm1E,
  input  logic [15:0]       imm2E,
  input  logic [31:0]       pcE,
  input  logic [31:0]       PcPlus4E,
  input  logic              ds_validE,
  input  logic              redirect_ready,
  output logic              actual_take1E,
  output logic              actual_take2E,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              flush_front,
  output logic              kill_slaveE,
  output logic              nullify_ds,
  output logic              stall_req,
  output logic [CNT_W-1:0]  mispred_cnt
);

  resolve_state_t   state_q;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             lnt_q;        // pending redirect came from likely-not-taken
  logic             nul_pend_q;   // correctly predicted slave likely-not-taken awaits its delay slot
  logic             redirect_valid_q, stall_req_q;

  logic take1, likely1, take2, likely2;
  logic sel_pred, sel_take, sel_likely, evaluate, mispred, lnt, ds_arrive;
  logic [31:0] sel_pc;
  logic [15:0] sel_imm;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  br_cmp #(.TYPE_W(TYPE_W)) u_cmp1 (
    .a_i(rs1E), .b_i(rt1E), .type_i(br_type1E), .take_o(take1), .likely_o(likely1)
  );

  br_cmp #(.TYPE_W(TYPE_W)) u_cmp2 (
    .a_i(rs2E), .b_i(rt2E), .type_i(br_type2E), .take_o(take2), .likely_o(likely2)
  );

  // Select the evaluated slot (master wins) and derive mispredict and pulse outputs.
  always_comb begin
    sel_pred      = branch1E ? pred_take1E : pred_take2E;
    sel_take      = branch1E ? take1       : take2;
    sel_likely    = branch1E ? likely1     : likely2;
    sel_pc        = branch1E ? pcE         : PcPlus4E;
    sel_imm       = branch1E ? imm1E       : imm2E;
    evaluate      = rst & (state_q == ST_IDLE) & ~stall_e & (branch1E | branch2E);
    mispred       = evaluate & (sel_pred ^ sel_take);
    lnt           = sel_likely & ~sel_take;
    ds_arrive     = ds_validE & ~stall_e;
    redirect_pc_d = sel_take ? br_target(sel_pc, sel_imm) : sel_pc + DS_OFFSET;
    actual_take1E = rst & branch1E & take1;
    actual_take2E = rst & branch2E & take2;
    flush_front   = (mispred & branch1E) | ((state_q == ST_WAIT_DS) & ds_arrive);
    kill_slaveE   = (state_q == ST_WAIT_DS) & ds_arrive;
    nullify_ds    = (evaluate & branch1E & lnt)
                  | ((state_q == ST_WAIT_DS) & ds_arrive & lnt_q)
                  | ((state_q == ST_IDLE) & nul_pend_q & ds_arrive);
  end

  // Resolver FSM with latched redirect target, registered handshake outputs and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      redirect_pc_q    <= '0;
      cnt_q            <= '0;
      lnt_q            <= 1'b0;
      nul_pend_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      stall_req_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ds_arrive) nul_pend_q <= 1'b0;
          if (mispred) begin
            cnt_q         <= sat_inc(cnt_q);
            redirect_pc_q <= redirect_pc_d;
            lnt_q         <= lnt & ~branch1E;
            if (branch1E) begin
              state_q          <= ST_REDIRECT;
              redirect_valid_q <= 1'b1;
              stall_req_q      <= 1'b1;
            end else begin
              state_q <= ST_WAIT_DS;
            end
          end else if (evaluate & ~branch1E & lnt) begin
            nul_pend_q <= 1'b1;
          end
        end
        ST_WAIT_DS: begin
          if (ds_arrive) begin
            state_q          <= ST_REDIRECT;
            redirect_valid_q <= 1'b1;
            stall_req_q      <= 1'b1;
            lnt_q            <= 1'b0;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
            stall_req_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Both slots holding a branch in one bundle is never issued.
  assert property (@(posedge clk) disable iff (!rst) !(branch1E && branch2E));

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign stall_req      = stall_req_q;
  assign mispred_cnt    = cnt_q;

endmodule
